// File: rtl/reverse_bits_pipe.sv
// rtl/reverse_bits_pipe.sv - registered, flow-controlled bit/group permutation stage
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   din/mode qualify
//   in_ready   block can accept a word this cycle (combinational)
//   din        input word, W bits
//   mode       0 pass, 1 full reverse, 2 reverse bits in each group, 3 reverse group order
//   out_valid  dout holds a result
//   out_ready  consumer accepts dout this cycle
//   dout       permuted word, W bits
//   out_mode   mode the current dout was produced with
//   word_cnt   delivered words, saturating at all-ones

module reverse_bits_pipe #(
    parameter int W     = 16,
    parameter int G     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     din,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     dout,
    output logic [1:0]       out_mode,
    output logic [CNT_W-1:0] word_cnt
);

    localparam int NG = W / G;

    if (G < 1) begin : g_bad_group
        $error("reverse_bits_pipe: G must be >= 1");
    end
    if ((G >= 1) && (W % G != 0)) begin : g_bad_width
        $error("reverse_bits_pipe: W must be a multiple of G");
    end

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state;

    logic [W-1:0] perm_full;
    logic [W-1:0] perm_grp;
    logic [W-1:0] perm_ord;
    logic [W-1:0] perm;
    logic         accept;
    logic         deliver;

    // Pure wiring permutations; only the selected one is registered.
    for (genvar i = 0; i < W; i++) begin : g_full
        assign perm_full[i] = din[W-1-i];
    end

    for (genvar k = 0; k < NG; k++) begin : g_grp
        for (genvar j = 0; j < G; j++) begin : g_bit
            assign perm_grp[k*G+j] = din[k*G+G-1-j];
            assign perm_ord[k*G+j] = din[(NG-1-k)*G+j];
        end
    end

    always_comb begin
        perm = din;
        case (mode)
            2'd0:    perm = din;
            2'd1:    perm = perm_full;
            2'd2:    perm = perm_grp;
            2'd3:    perm = perm_ord;
            default: perm = din;
        endcase
    end

    assign out_valid = (state == FULL);

    // A full register can still take a word in the same cycle it is drained,
    // which is what gives one word per cycle under continuous flow.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign deliver  = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            dout     <= '0;
            out_mode <= 2'd0;
            word_cnt <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state    <= FULL;
                        dout     <= perm;
                        out_mode <= mode;
                    end
                end
                FULL: begin
                    // accept implies out_ready here, so the held word is
                    // leaving in the same cycle the new one lands.
                    if (accept) begin
                        dout     <= perm;
                        out_mode <= mode;
                    end else if (out_ready) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase

            if (deliver && (word_cnt != {CNT_W{1'b1}})) begin
                word_cnt <= word_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reverse_bits_pipe.sv
// tb/tb_reverse_bits_pipe.sv - scoreboard bench for reverse_bits_pipe

module tb_reverse_bits_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] din;
    logic [1:0]  mode;
    logic [15:0] exp_in;

    logic        in_ready;
    logic        out_valid;
    logic [15:0] dout;
    logic [1:0]  out_mode;
    logic [3:0]  word_cnt;

    logic        g1_in_ready, g1_out_valid;
    logic [15:0] g1_dout;
    logic [1:0]  g1_out_mode;
    logic [3:0]  g1_word_cnt;
    logic        gw_in_ready, gw_out_valid;
    logic [15:0] gw_dout;
    logic [1:0]  gw_out_mode;
    logic [3:0]  gw_word_cnt;

    int checks;
    int errors;
    int accepted;
    logic [17:0] sb_q[$];

    reverse_bits_pipe #(.W(16), .G(8), .CNT_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .din(din), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .dout(dout), .out_mode(out_mode), .word_cnt(word_cnt)
    );

    reverse_bits_pipe #(.W(16), .G(1), .CNT_W(4)) u_g1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(g1_in_ready),
        .din(din), .mode(mode), .out_valid(g1_out_valid), .out_ready(out_ready),
        .dout(g1_dout), .out_mode(g1_out_mode), .word_cnt(g1_word_cnt)
    );

    reverse_bits_pipe #(.W(16), .G(16), .CNT_W(4)) u_gw (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(gw_in_ready),
        .din(din), .mode(mode), .out_valid(gw_out_valid), .out_ready(out_ready),
        .dout(gw_dout), .out_mode(gw_out_mode), .word_cnt(gw_word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rev8(input logic [7:0] b);
        return {b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7]};
    endfunction

    // Independent W=16/G=8 formulation: byte-level reversal and swap.
    function automatic logic [15:0] ref_perm(input logic [15:0] d, input logic [1:0] m);
        case (m)
            2'd0:    return d;
            2'd1:    return {rev8(d[7:0]), rev8(d[15:8])};
            2'd2:    return {rev8(d[15:8]), rev8(d[7:0])};
            default: return {d[7:0], d[15:8]};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Record every word the DUT accepts.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            sb_q.push_back({mode, exp_in});
            accepted++;
        end
    end

    // Compare every word the DUT delivers.
    always @(negedge clk) begin
        logic [17:0] e;
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got dout %0h with no expected word", dout);
            end else begin
                e = sb_q.pop_front();
                if (dout !== e[15:0] || out_mode !== e[17:16]) begin
                    errors++;
                    $display("FAIL sb_data: got %0h mode %0d expected %0h mode %0d",
                             dout, out_mode, e[15:0], e[17:16]);
                end
            end
        end
    end

    task automatic send(input logic [15:0] d, input logic [1:0] m, input logic [15:0] e);
        int n;
        din      = d;
        mode     = m;
        exp_in   = e;
        in_valid = 1'b1;
        n        = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready %0b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", sb_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] t1;
        logic [15:0] t6;
        checks    = 0;
        errors    = 0;
        accepted  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        din       = '0;
        mode      = 2'd0;
        exp_in    = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_dout", dout, 0);
        check("rst_out_mode", out_mode, 0);
        check("rst_word_cnt", word_cnt, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: the four modes on one word, one cycle latency
        t1 = 16'b1000000001111000;
        send(t1, 2'd0, 16'b1000000001111000);
        check("t1_latency_valid", out_valid, 1);
        check("t1_latency_dout", dout, 16'b1000000001111000);
        send(t1, 2'd1, 16'b0001111000000001);
        send(t1, 2'd2, 16'b0000000100011110);
        send(t1, 2'd3, 16'b0111100010000000);
        drain();
        check("t1_word_cnt", word_cnt, 4);

        // 2: back-to-back with saturation
        for (int i = 0; i < 20; i++) begin
            logic [15:0] d;
            logic [1:0]  m;
            d = 16'h1357 * 16'(i + 1);
            m = 2'(i);
            send(d, m, ref_perm(d, m));
            check("t2_in_ready", in_ready, 1);
        end
        drain();
        check("t2_word_cnt_sat", word_cnt, 15);

        // 3: backpressure holds the word
        send(16'hF000, 2'd1, 16'h000F);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            din    = 16'h1234 + 16'(i);
            mode   = 2'd0;
            exp_in = din;
            @(negedge clk);
            check("t3_hold_dout", dout, 16'h000F);
            check("t3_hold_mode", out_mode, 1);
            check("t3_in_ready", in_ready, 0);
            check("t3_out_valid", out_valid, 1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("t3_next_dout", dout, 16'h1238);
        drain();

        // 4: random valid/ready, all modes
        accepted = 0;
        for (int c = 0; c < 20000 && accepted < 1000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            din       = 16'($urandom);
            mode      = 2'($urandom_range(0, 3));
            exp_in    = ref_perm(din, mode);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("t4_accepted", (accepted >= 1000), 1);
        drain();

        // 5: reset while holding a word
        out_ready = 1'b0;
        send(16'hA5C3, 2'd2, ref_perm(16'hA5C3, 2'd2));
        check("t5_pre_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_valid", out_valid, 0);
        check("t5_async_cnt", word_cnt, 0);
        sb_q.delete();
        @(posedge clk);
        #3;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(16'h00FF, 2'd3, 16'hFF00);
        check("t5_resume_dout", dout, 16'hFF00);
        drain();
        check("t5_resume_cnt", word_cnt, 1);

        // 6: G=1 and G=W equivalences
        t6 = 16'b1000000000000111;
        send(t6, 2'd0, 16'h8007);
        check("t6_g1_m0", g1_dout, 16'h8007);
        check("t6_gw_m0", gw_dout, 16'h8007);
        send(t6, 2'd1, 16'hE001);
        check("t6_g1_m1", g1_dout, 16'hE001);
        check("t6_gw_m1", gw_dout, 16'hE001);
        send(t6, 2'd2, 16'h01E0);
        check("t6_g1_m2", g1_dout, 16'h8007);
        check("t6_gw_m2", gw_dout, 16'hE001);
        send(t6, 2'd3, 16'h0780);
        check("t6_g1_m3", g1_dout, 16'hE001);
        check("t6_gw_m3", gw_dout, 16'h8007);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
